// File: rtl/demux_unit_reg.sv
// demux_unit_reg: registered 1-to-N demultiplexer with a valid/ready handshake.
// Define DEMUX_SEL_ERR_EN to add the sticky sel_err flag and err_sel capture.
module demux_unit_reg #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
`ifdef DEMUX_SEL_ERR_EN
    ,
    output logic               sel_err,
    output logic [SEL_W-1:0]   err_sel
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DATA_W-1:0]  data_q;
    logic [SEL_W-1:0]   sel_q;
    logic               load;
    logic               sel_rdy;
    logic               legal;
    logic               accept;
    logic               deliver;

    // Only the addressed consumer's ready matters; the others are ignored.
    always_comb begin
        sel_rdy = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (sel_q == SEL_W'(k)) sel_rdy = out_ready[k];
        end
    end

    always_comb begin
        out_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_valid[k] = (state_q == FULL) && (sel_q == SEL_W'(k));
        end
    end

    assign legal    = {1'b0, in_sel} < (SEL_W+1)'(NUM_OUT);
    assign in_ready = reset_n && ((state_q == EMPTY) || sel_rdy);
    assign accept   = in_valid && in_ready;
    assign deliver  = (state_q == FULL) && sel_rdy;
    assign out_data = data_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept && legal) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (deliver) begin
                    // An illegal word arriving with a deliver still drains us.
                    if (accept && legal) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= in_data;
                sel_q  <= in_sel;
            end
        end
    end

`ifdef DEMUX_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
            err_sel <= '0;
        end else if (accept && !legal) begin
            sel_err <= 1'b1;
            if (!sel_err) err_sel <= in_sel;
        end
    end
`endif

endmodule

// File: tb/tb_demux_unit_reg.sv
// tb_demux_unit_reg: directed and random stimulus against a one-slot queue model.
// Runs a 4-channel and a 3-channel instance side by side on shared inputs.
module tb_demux_unit_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic [3:0] out_ready;

    logic       in_ready0, in_ready1;
    logic [7:0] out_data0, out_data1;
    logic [3:0] out_valid0;
    logic [2:0] out_valid1;
`ifdef DEMUX_SEL_ERR_EN
    logic       sel_err0, sel_err1;
    logic [1:0] err_sel0, err_sel1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_unit_reg #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready)
`ifdef DEMUX_SEL_ERR_EN
        , .sel_err(sel_err0), .err_sel(err_sel0)
`endif
    );

    demux_unit_reg #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready[2:0])
`ifdef DEMUX_SEL_ERR_EN
        , .sel_err(sel_err1), .err_sel(err_sel1)
`endif
    );

    // Model: each instance holds a queue of at most one pending word.
    int         nout[2] = '{4, 3};
    int         m_cnt[2];
    logic [7:0] m_data[2];
    int         m_sel[2];
    bit         m_err[2];
    int         m_esel[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_rdy(int i);
        return reset_n && (m_cnt[i] == 0 || out_ready[m_sel[i]]);
    endfunction

    function automatic logic [31:0] m_valid(int i);
        return (m_cnt[i] != 0) ? (32'd1 << m_sel[i]) : 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_data[i] = 8'd0;
            m_sel[i]  = 0;
            m_err[i]  = 0;
            m_esel[i] = 0;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            logic acc, del;
            if (!reset_n) begin
                m_cnt[i]  = 0;
                m_data[i] = 8'd0;
                m_sel[i]  = 0;
                m_err[i]  = 0;
                m_esel[i] = 0;
            end else begin
                acc = in_valid && m_rdy(i);
                del = (m_cnt[i] != 0) && out_ready[m_sel[i]];
                if (del) m_cnt[i] = 0;
                if (acc) begin
                    if (int'(in_sel) < nout[i]) begin
                        m_cnt[i]  = 1;
                        m_data[i] = in_data;
                        m_sel[i]  = int'(in_sel);
                    end else if (!m_err[i]) begin
                        m_err[i]  = 1;
                        m_esel[i] = int'(in_sel);
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("rdy0", in_ready0, m_rdy(0));
        chk("rdy1", in_ready1, m_rdy(1));
        chk("valid0", out_valid0, m_valid(0));
        chk("valid1", out_valid1, m_valid(1));
        chk("data0", out_data0, m_data[0]);
        chk("data1", out_data1, m_data[1]);
`ifdef DEMUX_SEL_ERR_EN
        chk("err0", sel_err0, m_err[0]);
        chk("err1", sel_err1, m_err[1]);
        chk("esel0", err_sel0, m_esel[0]);
        chk("esel1", err_sel1, m_esel[1]);
`endif
    endtask

    // Drive after negedge, check before posedge, then advance one cycle.
    task automatic cycle(input logic rn, input logic [7:0] d,
                         input logic [1:0] s, input logic v,
                         input logic [3:0] r);
        reset_n   = rn;
        in_data   = d;
        in_sel    = s;
        in_valid  = v;
        out_ready = r;
        #1;
        compare_all();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_data   = 8'd0;
        in_sel    = 2'd0;
        in_valid  = 1'b1;
        out_ready = 4'hF;
        m_reset();
        @(posedge clk);
        @(negedge clk);

        cycle(1'b0, 8'd5, 2'd1, 1'b1, 4'hF);
        cycle(1'b0, 8'd5, 2'd1, 1'b1, 4'hF);
        chk("rst_valid", out_valid0, 4'b0000);
        chk("rst_data", out_data0, 8'd0);
        chk("rst_rdy_low", in_ready0, 1'b0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_rdy_rel", in_ready0, 1'b1);

        cycle(1'b1, 8'd23, 2'd0, 1'b1, 4'hF);
        chk("single_valid", out_valid0, 4'b0001);
        chk("single_data", out_data0, 8'd23);
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);
        chk("single_drain", out_valid0, 4'b0000);

        cycle(1'b1, 8'hCA, 2'd3, 1'b1, 4'b0111);
        chk("neg_valid", out_valid0, 4'b1000);
        chk("neg_data", out_data0, 8'hCA);
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'd99, 2'd1, 1'b1, 4'b0111);
        chk("neg_hold_rdy", in_ready0, 1'b0);
        chk("neg_hold_data", out_data0, 8'hCA);
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);
        chk("neg_released", out_valid0, 4'b0000);

        cycle(1'b1, 8'd10, 2'd1, 1'b1, 4'hF);
        chk("strm_v1", out_valid0, 4'b0010);
        cycle(1'b1, 8'd20, 2'd2, 1'b1, 4'hF);
        chk("strm_v2", out_valid0, 4'b0100);
        cycle(1'b1, 8'd30, 2'd1, 1'b1, 4'hF);
        chk("strm_v3", out_valid0, 4'b0010);
        cycle(1'b1, 8'd40, 2'd0, 1'b1, 4'hF);
        chk("strm_v4", out_valid0, 4'b0001);
        chk("strm_d4", out_data0, 8'd40);
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);

        cycle(1'b1, 8'd7, 2'd3, 1'b1, 4'hF);
        chk("ill_valid", out_valid1, 3'b000);
`ifdef DEMUX_SEL_ERR_EN
        chk("ill_err", sel_err1, 1'b1);
        chk("ill_esel", err_sel1, 2'd3);
`endif
        cycle(1'b1, 8'd9, 2'd2, 1'b1, 4'hF);
        chk("ok_valid", out_valid1, 3'b100);
`ifdef DEMUX_SEL_ERR_EN
        chk("ok_err_sticky", sel_err1, 1'b1);
`endif
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);

        cycle(1'b1, 8'd66, 2'd2, 1'b1, 4'b0000);
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'b0000);
        cycle(1'b0, 8'd0, 2'd0, 1'b0, 4'b0000);
        chk("mid_valid", out_valid0, 4'b0000);
        chk("mid_data", out_data0, 8'd0);
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);
        chk("mid_lost", out_valid0, 4'b0000);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 24) != 0),
                  8'($urandom), 2'($urandom), 1'($urandom),
                  4'($urandom));
        end
        cycle(1'b1, 8'd0, 2'd0, 1'b0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
